// File: rtl/fill_rect.sv
// fill_rect: rectangle filler for a pixel-plotting VGA adapter.
//
// On start it fills the inclusive rectangle (x0,y0)-(x1,y1), clipped to the
// screen, emitting one pixel per cycle. Pixels go column by column: y runs
// fastest, then x advances.
//
// Parameters: H_RES, V_RES (screen size), COLOUR_W (colour width),
//             XW, YW (coordinate widths).
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start                  fill request, held high until done is seen
//   x0, y0, x1, y1         rectangle corners, inclusive
//   mode                   colour mode (0 flat, 1 x-ramp, 2 y-ramp, 3 checker/flat)
//   colour_in              base colour
//   vga_x, vga_y           pixel coordinates, valid while vga_plot=1
//   vga_colour             pixel colour, valid while vga_plot=1
//   vga_plot               one pixel presented this cycle
//   busy                   fill in progress
//   done                   fill complete, held until start drops
//
// Build option: define FILL_CHECKER_EN to make mode 3 a checkerboard of
// colour_in and 0. Without it, mode 3 is the same as mode 0.
module fill_rect #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int COLOUR_W = 3,
  parameter int XW       = $clog2(H_RES),
  parameter int YW       = $clog2(V_RES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [XW-1:0]       x0,
  input  logic [YW-1:0]       y0,
  input  logic [XW-1:0]       x1,
  input  logic [YW-1:0]       y1,
  input  logic [1:0]          mode,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  function automatic logic [COLOUR_W-1:0] pixel_colour(
    input logic [1:0]          m,
    input logic [XW-1:0]       px,
    input logic [YW-1:0]       py,
    input logic [COLOUR_W-1:0] base
  );
    case (m)
      2'd1: return COLOUR_W'(px);
      2'd2: return COLOUR_W'(py);
`ifdef FILL_CHECKER_EN
      2'd3: return (px[0] ^ py[0]) ? '0 : base;
`else
      2'd3: return base;
`endif
      default: return base;
    endcase
  endfunction

  logic [1:0]          state;
  // Set once start has been seen low; a start that was already high when
  // reset released must not launch a fill.
  logic                armed;

  logic [XW-1:0]       x0_l, x1_l;
  logic [YW-1:0]       y0_l, y1_l;
  logic [1:0]          mode_l;
  logic [COLOUR_W-1:0] colour_l;

  logic [XW-1:0]       cx_p0;
  logic [YW-1:0]       cy_p0;
  logic [COLOUR_W-1:0] colour_p0;

  logic [XW-1:0]       x1_clip;
  logic [YW-1:0]       y1_clip;
  logic                empty;
  logic                last_px;

  logic                vld_p1;
  logic [XW-1:0]       x_p1;
  logic [YW-1:0]       y_p1;
  logic [COLOUR_W-1:0] colour_p1;
  logic                busy_p1;
  logic                done_p1;

  // Clipping to the right/bottom edge also makes an off-screen x0/y0 fall
  // out as empty, since x1_clip/y1_clip never exceed the last column/row.
  assign x1_clip   = (x1_l > X_MAX) ? X_MAX : x1_l;
  assign y1_clip   = (y1_l > Y_MAX) ? Y_MAX : y1_l;
  assign empty     = (x0_l > x1_clip) || (y0_l > y1_clip);
  assign last_px   = (cx_p0 == x1_l) && (cy_p0 == y1_l);
  assign colour_p0 = pixel_colour(mode_l, cx_p0, cy_p0, colour_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      if (!start) armed <= 1'b1;
      case (state)
        S_IDLE:  if (start && armed) state <= S_INIT;
        S_INIT:  state <= empty ? S_DONE : S_FILL;
        S_FILL:  if (last_px) state <= S_DONE;
        // Leave only after done has been shown for at least one cycle.
        S_DONE:  if (!start && done_p1) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: request capture and pixel counters
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      x0_l     <= x0;
      y0_l     <= y0;
      x1_l     <= x1;
      y1_l     <= y1;
      mode_l   <= mode;
      colour_l <= colour_in;
    end
    if (state == S_INIT) begin
      x1_l  <= x1_clip;
      y1_l  <= y1_clip;
      cx_p0 <= x0_l;
      cy_p0 <= y0_l;
    end
    if (state == S_FILL) begin
      if (cy_p0 == y1_l) begin
        cy_p0 <= y0_l;
        // No increment past the final column, so x never wraps.
        if (!last_px) cx_p0 <= cx_p0 + 1'b1;
      end else begin
        cy_p0 <= cy_p0 + 1'b1;
      end
    end
  end

  // Stage p1: registered pixel output and status
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      x_p1      <= '0;
      y_p1      <= '0;
      colour_p1 <= '0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      vld_p1  <= (state == S_FILL);
      busy_p1 <= (state == S_INIT) || (state == S_FILL);
      done_p1 <= (state == S_DONE) && !(done_p1 && !start);
      if (state == S_FILL) begin
        x_p1      <= cx_p0;
        y_p1      <= cy_p0;
        colour_p1 <= colour_p0;
      end
    end
  end

  assign vga_x      = x_p1;
  assign vga_y      = y_p1;
  assign vga_colour = colour_p1;
  assign vga_plot   = vld_p1;
  assign busy       = busy_p1;
  assign done       = done_p1;

endmodule

// File: tb/tb_fill_rect.sv
// Testbench for fill_rect: expected pixels are queued by the stimulus process
// and popped by an independent monitor whenever vga_plot is high.
module tb_fill_rect;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [1:0] mode;
  logic [2:0] colour_in;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  fill_rect dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .mode(mode), .colour_in(colour_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t sb[$];

  int errors = 0;
  int checks = 0;
  int mon_errs = 0;
  int mon_checks = 0;
  int plot_cnt = 0;
  int last_x = -1;
  int last_y = -1;
  int log_x [0:32767];
  int log_y [0:32767];
  int log_c [0:32767];

  // Monitor: every presented pixel must match the head of the scoreboard.
  initial begin
    pix_t e;
    forever begin
      @(posedge clk);
      #1;
      if (vga_plot) begin
        mon_checks++;
        if (plot_cnt < 32768) begin
          log_x[plot_cnt] = int'(vga_x);
          log_y[plot_cnt] = int'(vga_y);
          log_c[plot_cnt] = int'(vga_colour);
        end
        last_x = int'(vga_x);
        last_y = int'(vga_y);
        if (sb.size() == 0) begin
          mon_errs++;
          $display("FAIL plot_unexpected: got (%0d,%0d) c=%0d, required no plot",
                   vga_x, vga_y, vga_colour);
        end else begin
          e = sb.pop_front();
          if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
            mon_errs++;
            $display("FAIL plot_%0d: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                     plot_cnt, vga_x, vga_y, vga_colour, e.x, e.y, e.c);
          end
        end
        plot_cnt++;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push(input int px, input int py, input int pc);
    pix_t e;
    e.x = px;
    e.y = py;
    e.c = pc;
    sb.push_back(e);
  endtask

  function automatic int exp_colour(input int m, input int px, input int py, input int c);
    case (m)
      1: return px % 8;
      2: return py % 8;
      default: return c;
    endcase
  endfunction

  // Queue up to 'limit' pixels of the screen-clipped rectangle, column-major.
  task automatic push_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int m, input int c, input int limit);
    int xe, ye, n;
    xe = (ax1 > 159) ? 159 : ax1;
    ye = (ay1 > 119) ? 119 : ay1;
    n = 0;
    for (int xi = ax0; xi <= xe; xi++)
      for (int yi = ay0; yi <= ye; yi++)
        if (n < limit) begin
          push(xi, yi, exp_colour(m, xi, yi, c));
          n++;
        end
  endtask

  task automatic run_fill(input string nm, input int ax0, input int ay0,
                          input int ax1, input int ay1, input int m, input int c,
                          input int exp_plots, input int exp_lat, input bit scramble);
    int base, n;
    base = plot_cnt;
    @(posedge clk);
    #1;
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
    mode = 2'(m); colour_in = 3'(c);
    start = 1'b1;
    n = -1;
    while (n < 30000) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 0) begin
        x0 = 8'd7; y0 = 7'd7; x1 = 8'd8; y1 = 7'd8; mode = 2'd2; colour_in = 3'd1;
      end
      if (done) break;
    end
    check({nm, "_done_latency"}, n, exp_lat);
    #2;
    check({nm, "_plot_count"}, plot_cnt - base, exp_plots);
    check({nm, "_queue_left"}, sb.size(), 0);
    @(posedge clk);
    #1;
    check({nm, "_done_held"}, int'(done), 1);
    check({nm, "_plot_low_in_done"}, int'(vga_plot), 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_done_cleared"}, int'(done), 0);
    check({nm, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; mode = '0; colour_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_plot", int'(vga_plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_x", int'(vga_x), 0);
    check("reset_y", int'(vga_y), 0);
    check("reset_colour", int'(vga_colour), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full screen, x-ramp colour.
    base = plot_cnt;
    push_rect(0, 0, 159, 119, 1, 0, 1 << 30);
    run_fill("full", 0, 0, 159, 119, 1, 0, 19200, 19202, 1'b0);
    check("full_plot8_x", log_x[base + 7], 0);
    check("full_plot8_y", log_y[base + 7], 7);
    check("full_plot8_c", log_c[base + 7], 0);
    check("full_plot138_x", log_x[base + 137], 1);
    check("full_plot138_y", log_y[base + 137], 17);
    check("full_plot138_c", log_c[base + 137], 1);

    // Clipped at the bottom-right corner; inputs changed right after launch.
    push_rect(150, 110, 200, 127, 0, 6, 1 << 30);
    run_fill("clip", 150, 110, 200, 127, 0, 6, 100, 102, 1'b1);
    check("clip_last_x", last_x, 159);
    check("clip_last_y", last_y, 119);

    // Empty rectangle.
    run_fill("empty", 10, 0, 5, 3, 0, 2, 0, 2, 1'b0);

    // Mode 3, 2x2 at origin, colour 5.
`ifdef FILL_CHECKER_EN
    push(0, 0, 5); push(0, 1, 0); push(1, 0, 0); push(1, 1, 5);
`else
    push(0, 0, 5); push(0, 1, 5); push(1, 0, 5); push(1, 1, 5);
`endif
    run_fill("mode3", 0, 0, 1, 1, 3, 5, 4, 6, 1'b0);

    // Single pixel, y-ramp colour.
    push(3, 4, 4);
    run_fill("single", 3, 4, 3, 4, 2, 0, 1, 3, 1'b0);

    // Reset in the middle of a 10x10 fill, at the 50th plot.
    base = plot_cnt;
    push_rect(0, 0, 9, 9, 0, 3, 50);
    @(posedge clk);
    #1;
    x0 = 8'd0; y0 = 7'd0; x1 = 8'd9; y1 = 7'd9; mode = 2'd0; colour_in = 3'd3;
    start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (plot_cnt - base >= 50) break;
    end
    check("rstmid_reached_50", plot_cnt - base, 50);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rstmid_plot", int'(vga_plot), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rstmid_no_relaunch_busy", int'(busy), 0);
    check("rstmid_no_relaunch_plots", plot_cnt - base, 50);
    check("rstmid_queue", sb.size(), 0);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Fresh launch after start went low, narrow 1x3 column.
    push_rect(20, 5, 20, 7, 2, 0, 1 << 30);
    run_fill("relaunch", 20, 5, 20, 7, 2, 0, 3, 5, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    errors += mon_errs;
    checks += mon_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
